// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the logic-gate block self-test sequencer.
// GOLDEN holds the expected {y7..y1} outputs, indexed by the {a,b} input vector.
package gate_bist_pkg;

    localparam int VEC_W = 2;
    localparam int Y_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [Y_W-1:0] GOLDEN [0:3] = '{
        7'b1011100,
        7'b0101010,
        7'b0101110,
        7'b1000011
    };

endpackage

// File: rtl/gate_bist_golden.sv
// Combinational reference lookup: selects the expected gate outputs for the
// applied {a,b} vector and flags any bit that differs from the sampled outputs.
module gate_bist_golden
    import gate_bist_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic [Y_W-1:0]   y_in,
    output logic [Y_W-1:0]   diff,
    output logic             mismatch
);

    assign diff     = y_in ^ GOLDEN[vec];
    assign mismatch = |diff;

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for the two-input, seven-output gate block: sweeps all
// four input vectors, samples after a settle delay, and accumulates results.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [Y_W-1:0]   y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [Y_W-1:0]   fail_mask,
    output logic [VEC_W-1:0] fail_vec,
    output logic [ERR_W-1:0] err_count
);

    localparam int SC_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [VEC_W-1:0] vec;
    logic [SC_W-1:0]  settle_cnt;
    logic [PC_W-1:0]  pass_cnt;
    logic [Y_W-1:0]   diff;
    logic             mismatch;
    logic             sample;
    logic             last_sample;

    gate_bist_golden u_golden (
        .vec      (vec),
        .y_in     (y_in),
        .diff     (diff),
        .mismatch (mismatch)
    );

    assign sample      = (state == RUN) && (settle_cnt == SC_W'(SETTLE_CYCLES));
    assign last_sample = sample && (&vec) && (pass_cnt == PC_W'(NUM_PASSES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        a_out     = 1'b0;
        b_out     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy           = 1'b1;
                {a_out, b_out} = vec;
                if (abort)            state_nxt = IDLE;
                else if (last_sample) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results survive abort and done; only an accepted start or rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            fail_vec   <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        pass_cnt   <= '0;
                        pass       <= 1'b0;
                        fail_mask  <= '0;
                        fail_vec   <= '0;
                        err_count  <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        pass_cnt   <= '0;
                    end else if (sample) begin
                        settle_cnt <= '0;
                        vec        <= vec + 1'b1;
                        if (&vec) begin
                            pass_cnt <= last_sample ? '0 : pass_cnt + 1'b1;
                        end
                        if (mismatch) begin
                            fail_mask <= fail_mask | diff;
                            // Counter saturates, so zero means no earlier mismatch.
                            if (err_count == '0) fail_vec <= vec;
                            if (~&err_count) err_count <= err_count + 1'b1;
                        end
                        if (last_sample) begin
                            pass <= (err_count == '0) && !mismatch;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
Built-in self-test sequencer for the two-input, seven-output logic-gate block (outputs y1..y7).
- On start, steps the gate block's a/b inputs through all four vectors (00, 01, 10, 11).
- After a programmable settle delay, samples y1..y7 and compares them against a fixed golden truth table.
- Reports pass/fail, a per-output sticky mismatch mask, the first failing vector and an error count.
- Sits between the test/control logic and the gate block, and owns the block's inputs while busy.

Parameters:
- SETTLE_CYCLES, 2, wait cycles after applying a vector before sampling (0 allowed).
- NUM_PASSES, 1, number of full four-vector sweeps per start (>=1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a test; ignored while busy.
- abort  in  1  synchronous cancel of a running test.
- y_in  in  7  gate block outputs, bit0=y1 … bit6=y7.
- a_out  out  1  drives gate block input a.
- b_out  out  1  drives gate block input b.
- busy  out  1  high while a test is running.
- done  out  1  one-cycle pulse when a test completes (not on abort).
- pass  out  1  high after done if no mismatch occurred; held until the next start.
- fail_mask  out  7  sticky OR of (y_in XOR golden) over all samples.
- fail_vec  out  2  {a,b} of the first mismatching sample; valid when pass=0 after done.
- err_count  out  ERR_W  number of mismatching samples, saturating at all-ones.

Behaviour:
- Reset (async, rst=1): state=IDLE; a_out=b_out=0; busy=done=pass=0; fail_mask=0; fail_vec=0; err_count=0; all counters=0.
- Golden table, {y7..y1} per {a,b}:
  - 00 -> 7'b1011100
  - 01 -> 7'b0101010
  - 10 -> 7'b0101110
  - 11 -> 7'b1000011
- States: IDLE, RUN, DONE.
- IDLE:
  - a_out=b_out=0.
  - start=1 -> RUN next edge. Same edge: vec=00, settle_cnt=0, pass_cnt=0, fail_mask/fail_vec/err_count/pass cleared, busy=1.
- RUN:
  - a_out/b_out = vec. settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES, sample y_in this cycle. On mismatch:
    - fail_mask |= diff.
    - err_count += 1 (saturate).
    - If this is the first mismatch since start, fail_vec = vec.
  - In the sample cycle: settle_cnt resets to 0 and vec increments mod 4.
  - When vec wraps 11->00: pass_cnt increments. If pass_cnt==NUM_PASSES-1 -> DONE.
  - Each vector occupies exactly SETTLE_CYCLES+1 cycles. RUN lasts NUM_PASSES*4*(SETTLE_CYCLES+1) cycles; with defaults that is 12.
- DONE:
  - One cycle: done=1, busy=0, pass=(err_count==0 including the final sample), a_out=b_out=0.
  - Then IDLE. A start arriving in the DONE cycle is ignored.
- abort=1 in RUN:
  - Next edge -> IDLE, busy=0, a_out=b_out=0, no done pulse, pass=0.
  - fail_mask, fail_vec and err_count keep their partial values.
  - abort takes priority over the sample-cycle update in the same cycle; that sample is discarded.
- abort in IDLE or DONE: no effect.
- start while busy: no effect, including no clearing of results.
- Results (pass, fail_mask, fail_vec, err_count) are stable from done until the next accepted start.
- rst asserted mid-test: immediate return to the reset values, regardless of state.

Decomposition:
- Package gate_bist_pkg:
  - state enum {IDLE, RUN, DONE};
  - GOLDEN constant array [0:3] of 7-bit values;
  - VEC_W=2, Y_W=7 constants.
- One sub-module, gate_bist_golden: combinational vec->expected lookup plus diff = y_in ^ expected, returning diff and mismatch = |diff.
- The FSM, counters and result registers stay in gate_bist_ctrl.

Test Plan:
1. Good-DUT model, defaults, start pulse -> busy for 12 cycles; a/b show 00,01,10,11 for 3 cycles each; done pulses at cycle 13; pass=1, fail_mask=0, err_count=0.
2. Model with y2 stuck-at-0 -> done with pass=0, fail_mask=7'b0000010, fail_vec=01, err_count=3 (vectors 01, 10, 11).
3. NUM_PASSES=3, SETTLE_CYCLES=0, y7 stuck-at-1 -> busy 12 cycles; err_count=6 (vectors 01, 10 per pass); fail_mask=7'b1000000; fail_vec=01.
4. abort asserted in the sample cycle of vector 10 with a y1 fault on 10 -> no done pulse; busy low next cycle; err_count=0, pass=0; a new start then completes normally.
5. start re-pulsed mid-test and in the DONE cycle -> ignored; counters and sequence unchanged; exactly one done pulse.
6. ERR_W=2, all outputs inverted, NUM_PASSES=2 -> err_count saturates at 3; fail_mask=7'b1111111; fail_vec=00; rst asserted mid-run clears all outputs asynchronously.
